// File: rtl/fb_scanout_if.sv
// Framebuffer read port between the scanout engine and the 1-bit RAM.
// The scanout side drives the address; the RAM side returns the stored bit
// one clock later from its output register.
interface fb_scanout_if;
  logic [18:0] read_addr;
  logic        fb_data;

  modport master (output read_addr, input fb_data);
  modport slave  (input read_addr, output fb_data);
endinterface

// File: rtl/fb_scanout.sv
// fb_scanout: raster timing generator and pixel reader for a 1-bit
// framebuffer. Walks h/v counters through the VGA frame, generates the RAM
// address incrementally in raster order, and turns each returned bit into an
// RGB value. Sync and blank travel through the same two-stage pipeline as the
// RAM read, so every pin lines up two cycles after its counter position.
// The timing parameters default to 640x480@60; other geometries are accepted.
module fb_scanout #(
  parameter logic [23:0] FG_COLOR = 24'hFFFFFF,
  parameter logic [23:0] BG_COLOR = 24'h000000,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic         clk,
  input  logic         rst,
  fb_scanout_if.master fb,
  output logic [7:0]   vga_r,
  output logic [7:0]   vga_g,
  output logic [7:0]   vga_b,
  output logic         vga_hs,
  output logic         vga_vs,
  output logic         vga_blank_n,
  output logic         vblank,
  output logic         frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS_END   = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_BEG  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS_END   = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_BEG  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_END  = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [18:0]   ADDR_MAX    = 19'(H_ACTIVE * V_ACTIVE - 1);

  // ST_IDLE is the single cycle after reset release in which the counters
  // stay at (0,0) so that frame_start can already be high while (0,0) is held.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e        state_q;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [18:0]   addr_q, addr_d;
  logic          frame_start_q, frame_start_d;

  logic          visible_s;
  logic          hs_raw_s;
  logic          vs_raw_s;
  logic          wrap_s;

  // Stage 1: position attributes aligned with the RAM read in flight.
  logic          vis1_q, hs1_q, vs1_q;
  // Stage 2: pin registers.
  logic [23:0]   rgb_q;
  logic          hs_q, vs_q, blank_n_q;

  // Decode the current counter position into visibility and raw sync levels.
  always_comb begin
    visible_s = (h_q < H_VIS_END) && (v_q < V_VIS_END);
    hs_raw_s  = ~((h_q >= H_SYNC_BEG) && (h_q < H_SYNC_END));
    vs_raw_s  = ~((v_q >= V_SYNC_BEG) && (v_q < V_SYNC_END));
    wrap_s    = (h_q == H_LAST) && (v_q == V_LAST);
  end

  // Next counter position and next address; the address only advances on
  // visible pixels and saturates at the last pixel until the frame wraps.
  always_comb begin
    h_d    = h_q;
    v_d    = v_q;
    addr_d = addr_q;
    if (state_q == ST_RUN) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        if (v_q == V_LAST) begin
          v_d = '0;
        end else begin
          v_d = v_q + 1'b1;
        end
      end else begin
        h_d = h_q + 1'b1;
      end
      if (wrap_s) begin
        addr_d = 19'd0;
      end else if (visible_s && (addr_q != ADDR_MAX)) begin
        addr_d = addr_q + 19'd1;
      end else begin
        addr_d = addr_q;
      end
    end else begin
      h_d    = '0;
      v_d    = '0;
      addr_d = 19'd0;
    end
    frame_start_d = (h_d == '0) && (v_d == '0);
  end

  // Run-state FSM: one idle cycle after reset, then free-running.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_q <= ST_RUN;
        ST_RUN:  state_q <= ST_RUN;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Raster counters, read address and the frame-start strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_q           <= '0;
      v_q           <= '0;
      addr_q        <= 19'd0;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      addr_q        <= addr_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Stage 1: capture position attributes while the RAM fetches the pixel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vis1_q <= 1'b0;
      hs1_q  <= 1'b1;
      vs1_q  <= 1'b1;
    end else if (state_q == ST_RUN) begin
      vis1_q <= visible_s;
      hs1_q  <= hs_raw_s;
      vs1_q  <= vs_raw_s;
    end else begin
      vis1_q <= 1'b0;
      hs1_q  <= 1'b1;
      vs1_q  <= 1'b1;
    end
  end

  // Stage 2: colour-map the returned bit and register all pin values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb_q     <= 24'h000000;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
    end else begin
      if (vis1_q) begin
        rgb_q <= fb.fb_data ? FG_COLOR : BG_COLOR;
      end else begin
        rgb_q <= 24'h000000;
      end
      hs_q      <= hs1_q;
      vs_q      <= vs1_q;
      blank_n_q <= vis1_q;
    end
  end

  assign fb.read_addr  = addr_q;
  assign vga_r         = rgb_q[23:16];
  assign vga_g         = rgb_q[15:8];
  assign vga_b         = rgb_q[7:0];
  assign vga_hs        = hs_q;
  assign vga_vs        = vs_q;
  assign vga_blank_n   = blank_n_q;
  assign frame_start   = frame_start_q;
  // Left unregistered so drawing logic sees vertical blanking as early as possible.
  assign vblank        = (v_q >= V_VIS_END);

endmodule
